// File: rtl/pipeline_pkg.sv
// Shared definitions for the MEM/WB slice of the 5-stage MIPS pipeline.
// Holds the branch opcode values, the LoadByte encodings and the state
// type of the data-memory access FSM.
package pipeline_pkg;

  localparam logic [5:0] OPC_BEQ  = 6'h04;
  localparam logic [5:0] OPC_BNE  = 6'h05;
  localparam logic [5:0] OPC_BLEZ = 6'h06;
  localparam logic [5:0] OPC_BGTZ = 6'h07;

  localparam logic [1:0] LB_WORD     = 2'b00;
  localparam logic [1:0] LB_SIGNED   = 2'b01;
  localparam logic [1:0] LB_UNSIGNED = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_wb_stage_align.sv
// load_store_align: combinational byte-lane handling for the data bus.
//   addr_lo   - low two address bits selecting the byte lane
//   wr_byte   - store a single byte instead of a word
//   load_byte - load extraction mode (word / lb / lbu)
//   st_data   - store data from the register file
//   rd_data   - raw word returned by memory
//   be        - byte enables for the store
//   wdata     - lane-steered store data
//   ld_data   - extracted and extended load data
module load_store_align
  import pipeline_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic        wr_byte,
  input  logic [1:0]  load_byte,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic signed [7:0] byte_s;

  // Little-endian: byte lane n lives in bits [8n+7:8n]. Replicating the
  // byte on all lanes lets the enable alone pick the target lane.
  assign be     = wr_byte ? (4'b0001 << addr_lo) : 4'b1111;
  assign wdata  = wr_byte ? {4{st_data[7:0]}} : st_data;
  assign byte_s = rd_data[{addr_lo, 3'b000} +: 8];

  always_comb begin
    ld_data = rd_data;
    case (load_byte)
      LB_SIGNED:   ld_data = 32'(byte_s);
      LB_UNSIGNED: ld_data = {24'h0, byte_s};
      default:     ld_data = rd_data;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage plus MEM/WB pipeline register.
//   EX/MEM inputs  - ALU result/address, store data, PC value, opcode,
//                    destination, ALU flags and control bits
//   dmem_*         - req/ack data-memory bus (request side registered)
//   stall_o        - freezes the upstream pipeline during an access
//   redirect_o/_pc - branch-taken or register-jump PC redirect
//   bus_err_o      - one-cycle pulse when an access times out
//   *_Wb           - registered write-back bundle for the register file
module mem_wb_stage
  import pipeline_pkg::*;
#(
  parameter int         TIMEOUT  = 16,
  parameter logic [5:0] OP_BEQ   = OPC_BEQ,
  parameter logic [5:0] OP_BNE   = OPC_BNE,
  parameter logic [5:0] OP_BLEZ  = OPC_BLEZ,
  parameter logic [5:0] OP_BGTZ  = OPC_BGTZ
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALU_ans_Mem,
  input  logic [31:0] busB_Mem,
  input  logic [31:0] PC_Addr_Mem,
  input  logic [5:0]  OP_Mem,
  input  logic [4:0]  Reg_Target_Mem,
  input  logic        ZF_Mem,
  input  logic        OF_Mem,
  input  logic        Sign_Mem,
  input  logic        Branch_Mem,
  input  logic        MemToReg_Mem,
  input  logic        RegWr_Mem,
  input  logic        MemWr_Mem,
  input  logic        Jal_Mem,
  input  logic        Rtype_J_Mem,
  input  logic        Rtype_L_Mem,
  input  logic        WrByte_Mem,
  input  logic [1:0]  LoadByte_Mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        bus_err_o,
  output logic        RegWr_Wb,
  output logic [4:0]  Reg_Target_Wb,
  output logic [31:0] busW_Wb
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  mem_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             mem_op;
  logic             timeout_hit;
  logic             complete;
  logic             taken;
  logic [3:0]       be_p0;
  logic [31:0]      wdata_p0;
  logic [31:0]      ld_data_p0;
  logic [31:0]      busw_p0;

  assign mem_op = MemToReg_Mem | MemWr_Mem;

  load_store_align u_align (
    .addr_lo   (ALU_ans_Mem[1:0]),
    .wr_byte   (WrByte_Mem),
    .load_byte (LoadByte_Mem),
    .st_data   (busB_Mem),
    .rd_data   (dmem_rdata),
    .be        (be_p0),
    .wdata     (wdata_p0),
    .ld_data   (ld_data_p0)
  );

  // Ack takes priority over the timeout in the same cycle.
  assign timeout_hit = (state == WAIT) & ~dmem_ack & (cnt == CNT_W'(TIMEOUT - 1));

  // On timeout stall drops so the faulting instruction leaves the stage.
  always_comb begin
    stall_o  = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE: begin
        stall_o  = mem_op;
        complete = ~mem_op;
      end
      WAIT: begin
        stall_o  = ~dmem_ack & ~timeout_hit;
        complete = dmem_ack;
      end
      default: ;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    if (Branch_Mem) begin
      case (OP_Mem)
        OP_BEQ:  taken = ZF_Mem;
        OP_BNE:  taken = ~ZF_Mem;
        OP_BLEZ: taken = ZF_Mem | Sign_Mem;
        OP_BGTZ: taken = ~ZF_Mem & ~Sign_Mem;
        default: taken = 1'b0;
      endcase
    end
  end

  assign redirect_o    = (taken | Rtype_J_Mem) & ~stall_o;
  assign redirect_pc_o = Rtype_J_Mem ? ALU_ans_Mem : PC_Addr_Mem;

  assign busw_p0 = (Jal_Mem | Rtype_L_Mem) ? PC_Addr_Mem :
                   MemToReg_Mem            ? ld_data_p0  : ALU_ans_Mem;

  // ---- stage boundary: data-memory request registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= 4'b0000;
      dmem_addr  <= 32'h0;
      dmem_wdata <= 32'h0;
      bus_err_o  <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWr_Mem;
            dmem_be    <= be_p0;
            dmem_addr  <= {ALU_ans_Mem[31:2], 2'b00};
            dmem_wdata <= wdata_p0;
            cnt        <= '0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            state    <= IDLE;
          end else if (timeout_hit) begin
            dmem_req  <= 1'b0;
            bus_err_o <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage boundary: MEM/WB register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWr_Wb      <= 1'b0;
      Reg_Target_Wb <= 5'd0;
      busW_Wb       <= 32'h0;
    end else begin
      RegWr_Wb <= complete & RegWr_Mem & ~OF_Mem;
      if (complete) begin
        Reg_Target_Wb <= Reg_Target_Mem;
        busW_Wb       <= busw_p0;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALU_ans_Mem, busB_Mem, PC_Addr_Mem;
  logic [5:0]  OP_Mem;
  logic [4:0]  Reg_Target_Mem;
  logic        ZF_Mem, OF_Mem, Sign_Mem;
  logic        Branch_Mem, MemToReg_Mem, RegWr_Mem, MemWr_Mem;
  logic        Jal_Mem, Rtype_J_Mem, Rtype_L_Mem, WrByte_Mem;
  logic [1:0]  LoadByte_Mem;
  logic        dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        stall_o, redirect_o, bus_err_o;
  logic [31:0] redirect_pc_o;
  logic        RegWr_Wb;
  logic [4:0]  Reg_Target_Wb;
  logic [31:0] busW_Wb;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  mem_wb_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .ALU_ans_Mem(ALU_ans_Mem), .busB_Mem(busB_Mem), .PC_Addr_Mem(PC_Addr_Mem),
    .OP_Mem(OP_Mem), .Reg_Target_Mem(Reg_Target_Mem),
    .ZF_Mem(ZF_Mem), .OF_Mem(OF_Mem), .Sign_Mem(Sign_Mem),
    .Branch_Mem(Branch_Mem), .MemToReg_Mem(MemToReg_Mem), .RegWr_Mem(RegWr_Mem),
    .MemWr_Mem(MemWr_Mem), .Jal_Mem(Jal_Mem), .Rtype_J_Mem(Rtype_J_Mem),
    .Rtype_L_Mem(Rtype_L_Mem), .WrByte_Mem(WrByte_Mem), .LoadByte_Mem(LoadByte_Mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .stall_o(stall_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .bus_err_o(bus_err_o),
    .RegWr_Wb(RegWr_Wb), .Reg_Target_Wb(Reg_Target_Wb), .busW_Wb(busW_Wb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    ALU_ans_Mem = 0; busB_Mem = 0; PC_Addr_Mem = 0; OP_Mem = 0; Reg_Target_Mem = 0;
    ZF_Mem = 0; OF_Mem = 0; Sign_Mem = 0; Branch_Mem = 0; MemToReg_Mem = 0;
    RegWr_Mem = 0; MemWr_Mem = 0; Jal_Mem = 0; Rtype_J_Mem = 0; Rtype_L_Mem = 0;
    WrByte_Mem = 0; LoadByte_Mem = 0;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_in();
    dmem_rdata = 0;
    dmem_ack   = 0;
    rst        = 1;
    next_edge();
    next_edge();
    chk("rst_req",    {31'b0, dmem_req},  32'h0);
    chk("rst_we",     {31'b0, dmem_we},   32'h0);
    chk("rst_be",     {28'b0, dmem_be},   32'h0);
    chk("rst_addr",   dmem_addr,          32'h0);
    chk("rst_wdata",  dmem_wdata,         32'h0);
    chk("rst_berr",   {31'b0, bus_err_o}, 32'h0);
    chk("rst_regwr",  {31'b0, RegWr_Wb},  32'h0);
    chk("rst_target", {27'b0, Reg_Target_Wb}, 32'h0);
    chk("rst_busw",   busW_Wb,            32'h0);
    rst = 0;

    // ALU add
    ALU_ans_Mem = 32'h1234; RegWr_Mem = 1; Reg_Target_Mem = 5;
    @(negedge clk);
    chk("add_stall", {31'b0, stall_o}, 32'h0);
    chk("add_redir", {31'b0, redirect_o}, 32'h0);
    next_edge();
    chk("add_regwr",  {31'b0, RegWr_Wb}, 32'h1);
    chk("add_target", {27'b0, Reg_Target_Wb}, 32'd5);
    chk("add_busw",   busW_Wb, 32'h1234);

    // ALU result with overflow is not written
    ALU_ans_Mem = 32'h5555; OF_Mem = 1; Reg_Target_Mem = 6;
    next_edge();
    chk("of_regwr", {31'b0, RegWr_Wb}, 32'h0);
    clear_in();

    // lb, ack after three wait cycles
    ALU_ans_Mem = 32'h102; MemToReg_Mem = 1; RegWr_Mem = 1; LoadByte_Mem = 2'b01;
    Reg_Target_Mem = 7;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (stall_o) n++;
      next_edge();
      if (i == 0) begin
        chk("lb_req",  {31'b0, dmem_req}, 32'h1);
        chk("lb_addr", dmem_addr, 32'h100);
        chk("lb_we",   {31'b0, dmem_we}, 32'h0);
      end
    end
    chk("lb_stall_cycles", n, 32'd4);
    chk("lb_bubble", {31'b0, RegWr_Wb}, 32'h0);
    dmem_ack = 1; dmem_rdata = 32'h0080_0000;
    @(negedge clk);
    chk("lb_ack_stall", {31'b0, stall_o}, 32'h0);
    next_edge();
    dmem_ack = 0;
    chk("lb_busw",   busW_Wb, 32'hFFFF_FF80);
    chk("lb_regwr",  {31'b0, RegWr_Wb}, 32'h1);
    chk("lb_target", {27'b0, Reg_Target_Wb}, 32'd7);
    chk("lb_req_drop", {31'b0, dmem_req}, 32'h0);
    clear_in();

    // lbu, lane 3, immediate ack
    ALU_ans_Mem = 32'h303; MemToReg_Mem = 1; RegWr_Mem = 1; LoadByte_Mem = 2'b10;
    next_edge();
    dmem_ack = 1; dmem_rdata = 32'h9A00_0000;
    next_edge();
    dmem_ack = 0;
    chk("lbu_busw", busW_Wb, 32'h0000_009A);
    clear_in();

    // word load, immediate ack
    ALU_ans_Mem = 32'h40; MemToReg_Mem = 1; RegWr_Mem = 1;
    next_edge();
    chk("lw_be", {28'b0, dmem_be}, 32'hF);
    dmem_ack = 1; dmem_rdata = 32'hCAFE_F00D;
    next_edge();
    dmem_ack = 0;
    chk("lw_busw", busW_Wb, 32'hCAFE_F00D);
    clear_in();

    // sb to lane 3, immediate ack
    ALU_ans_Mem = 32'h203; busB_Mem = 32'hAB; MemWr_Mem = 1; WrByte_Mem = 1;
    @(negedge clk);
    chk("sb_stall", {31'b0, stall_o}, 32'h1);
    next_edge();
    chk("sb_be",    {28'b0, dmem_be}, 32'h8);
    chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    chk("sb_we",    {31'b0, dmem_we}, 32'h1);
    chk("sb_addr",  dmem_addr, 32'h200);
    dmem_ack = 1;
    @(negedge clk);
    chk("sb_ack_stall", {31'b0, stall_o}, 32'h0);
    next_edge();
    dmem_ack = 0;
    chk("sb_regwr", {31'b0, RegWr_Wb}, 32'h0);
    clear_in();

    // branches
    Branch_Mem = 1; OP_Mem = 6'h05; ZF_Mem = 0; PC_Addr_Mem = 32'h400;
    #1;
    chk("bne_redir", {31'b0, redirect_o}, 32'h1);
    chk("bne_pc",    redirect_pc_o, 32'h400);
    OP_Mem = 6'h04; #1;
    chk("beq_nt", {31'b0, redirect_o}, 32'h0);
    OP_Mem = 6'h06; Sign_Mem = 1; #1;
    chk("blez_t", {31'b0, redirect_o}, 32'h1);
    OP_Mem = 6'h07; #1;
    chk("bgtz_nt", {31'b0, redirect_o}, 32'h0);
    Sign_Mem = 0; #1;
    chk("bgtz_t", {31'b0, redirect_o}, 32'h1);
    OP_Mem = 6'h08; #1;
    chk("other_nt", {31'b0, redirect_o}, 32'h0);
    OP_Mem = 6'h05; Branch_Mem = 0; #1;
    chk("nobranch", {31'b0, redirect_o}, 32'h0);
    next_edge();
    clear_in();

    // jalr
    Rtype_J_Mem = 1; Rtype_L_Mem = 1; RegWr_Mem = 1; ALU_ans_Mem = 32'h800;
    PC_Addr_Mem = 32'h44; Reg_Target_Mem = 31;
    @(negedge clk);
    chk("jalr_redir", {31'b0, redirect_o}, 32'h1);
    chk("jalr_pc",    redirect_pc_o, 32'h800);
    next_edge();
    chk("jalr_busw",   busW_Wb, 32'h44);
    chk("jalr_target", {27'b0, Reg_Target_Wb}, 32'd31);
    chk("jalr_regwr",  {31'b0, RegWr_Wb}, 32'h1);
    clear_in();

    // load that never gets an ack
    ALU_ans_Mem = 32'h10; MemToReg_Mem = 1; RegWr_Mem = 1; Reg_Target_Mem = 9;
    n = 0;
    @(negedge clk);
    while (stall_o && n < 40) begin
      chk("to_no_berr", {31'b0, bus_err_o}, 32'h0);
      @(negedge clk);
      n++;
    end
    chk("to_stall_cycles", n, 32'd16);
    clear_in();
    next_edge();
    chk("to_berr",  {31'b0, bus_err_o}, 32'h1);
    chk("to_regwr", {31'b0, RegWr_Wb}, 32'h0);
    chk("to_req",   {31'b0, dmem_req}, 32'h0);
    next_edge();
    chk("to_berr_pulse", {31'b0, bus_err_o}, 32'h0);
    chk("to_idle_stall", {31'b0, stall_o}, 32'h0);

    // reset during WAIT, then a late ack
    ALU_ans_Mem = 32'h2F4; busB_Mem = 32'h1357_9BDF; MemWr_Mem = 1;
    next_edge();
    next_edge();
    chk("rw_req", {31'b0, dmem_req}, 32'h1);
    rst = 1;
    clear_in();
    #1;
    chk("rw_req0",   {31'b0, dmem_req}, 32'h0);
    chk("rw_we0",    {31'b0, dmem_we}, 32'h0);
    chk("rw_be0",    {28'b0, dmem_be}, 32'h0);
    chk("rw_addr0",  dmem_addr, 32'h0);
    chk("rw_wdata0", dmem_wdata, 32'h0);
    chk("rw_busw0",  busW_Wb, 32'h0);
    chk("rw_stall0", {31'b0, stall_o}, 32'h0);
    next_edge();
    rst = 0;
    dmem_ack = 1;
    RegWr_Mem = 0;
    next_edge();
    dmem_ack = 0;
    chk("late_ack_req",   {31'b0, dmem_req}, 32'h0);
    chk("late_ack_regwr", {31'b0, RegWr_Wb}, 32'h0);
    chk("late_ack_berr",  {31'b0, bus_err_o}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
